fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 6 +
 rtl/skid_buf2.sv | 49 ++++
 rtl/fifo_rd_stream.sv | 63 ++++++
 tb/tb_fifo_rd_stream.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared FIFO read-side defaults: payload width, burst length and beat-counter width.
package fifo_rd_stream_pkg;
  localparam int DATA_LEN_DEF  = 32;
  localparam int BURST_LEN_DEF = 16;
  localparam int CNT_W         = 8;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; head word is registered and holds its value once the buffer empties.
// Same-cycle push and pop keep occupancy unchanged; caller guarantees no push when full after pop.
module skid_buf2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic         hd;
  logic         tl;
  logic         hd_nxt;
  logic [1:0]   occ_nxt;
  logic [W-1:0] head_nxt;

  always_comb begin
    hd_nxt   = hd ^ pop;
    occ_nxt  = occ + {1'b0, push} - {1'b0, pop};
    head_nxt = head_dat;
    // A word being written this cycle becomes the head if it lands in the next head slot.
    if (occ_nxt != 2'd0) begin
      head_nxt = (push && (tl == hd_nxt)) ? push_dat : mem[hd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      hd       <= 1'b0;
      tl       <= 1'b0;
      occ      <= 2'd0;
      head_dat <= '0;
    end else begin
      if (push) begin
        mem[tl] <= push_dat;
      end
      hd       <= hd_nxt;
      tl       <= tl ^ push;
      occ      <= occ_nxt;
      head_dat <= head_nxt;
    end
  end
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a valid/ready burst stream; first beat 2 cycles after the pop.
// Pops only while buffered + in-flight words stay below 2, so m_ready_i=0 stalls after two pops.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                fifo_empty_i,
  input  logic [DATA_LEN-1:0] fifo_rdata_i,
  output logic                fifo_ren_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_LEN-1:0] m_data_o,
  output logic                m_last_o,
  output logic [CNT_W-1:0]    beat_cnt_o
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  logic                inflight;
  logic [1:0]          occ;
  logic [DATA_LEN-1:0] head_dat;
  logic [CNT_W-1:0]    beat_cnt;
  logic                hs;
  logic                pop;
  logic [2:0]          level;

  assign hs    = m_valid_o & m_ready_i;
  // hs implies occ >= 1, so the subtraction cannot wrap.
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, hs};

  assign fifo_ren_o = rst_n & ~fifo_empty_i & (level < 3'd2);
  assign pop        = fifo_ren_o & ~fifo_empty_i;

  assign m_valid_o  = rst_n & (occ != 2'd0);
  assign m_data_o   = rst_n ? head_dat : '0;
  assign beat_cnt_o = rst_n ? beat_cnt : '0;
  assign m_last_o   = m_valid_o & (beat_cnt == LAST_IDX);

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= pop;
      if (hs) begin
        beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end

  skid_buf2 #(.W(DATA_LEN)) u_buf (
    .clk      (rclk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_dat (fifo_rdata_i),
    .pop      (hs),
    .head_dat (head_dat),
    .occ      (occ)
  );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: FIFO model feeds the DUT, loaded words queue as expected beats, monitors compare.
module tb_fifo_rd_stream;
  logic        rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic        rst_n;
  logic        fifo_empty;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_ren;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [7:0]  beat_cnt;

  logic        rst2_n;
  logic        en2;
  logic        empty2;
  logic [7:0]  rdata2 = '0;
  logic        ren2;
  logic        valid2;
  logic        ready2;
  logic [7:0]  data2;
  logic        last2;
  logic [7:0]  cnt2;
  logic [7:0]  pops2 = '0;

  int          total = 0;
  int          passed = 0;
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  int          fq_n = 0;
  logic        empty_force = 1'b0;
  int          k2 = 0;

  assign fifo_empty = empty_force || (fq_n == 0);
  assign empty2     = !en2 || (pops2 >= 8'd6);

  fifo_rd_stream dut (
    .rclk(rclk), .rst_n(rst_n), .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata),
    .fifo_ren_o(fifo_ren), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .m_last_o(m_last), .beat_cnt_o(beat_cnt)
  );

  fifo_rd_stream #(.DATA_LEN(8), .BURST_LEN(2)) dut2 (
    .rclk(rclk), .rst_n(rst2_n), .fifo_empty_i(empty2), .fifo_rdata_i(rdata2),
    .fifo_ren_o(ren2), .m_valid_o(valid2), .m_ready_i(ready2), .m_data_o(data2),
    .m_last_o(last2), .beat_cnt_o(cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic load(input logic [31:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fq_n++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge rclk);
      n++;
    end
    repeat (3) @(posedge rclk);
    #1;
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  // FIFO read-port model: data appears one cycle after an accepted pop.
  always @(posedge rclk) begin
    if (fifo_ren && !fifo_empty) begin
      fifo_rdata <= fq.pop_front();
      fq_n       <= fq_n - 1;
    end else begin
      fifo_rdata <= 32'hDEAD_BEEF;
    end
  end

  always @(posedge rclk) begin
    if (!rst2_n) pops2 <= '0;
    else if (ren2 && !empty2) begin
      pops2  <= pops2 + 8'd1;
      rdata2 <= pops2 + 8'd1;
    end
  end

  int          bcnt = 0;
  logic [31:0] last_dat = '0;
  logic        pv_stall = 1'b0;
  logic [31:0] pv_dat = '0;
  logic [7:0]  pv_cnt = '0;

  always @(negedge rclk) begin
    if (!rst_n) begin
      bcnt     = 0;
      last_dat = '0;
      pv_stall = 1'b0;
    end else begin
      if (pv_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", m_data, pv_dat);
        check("stall_cnt", 32'(beat_cnt), 32'(pv_cnt));
      end
      if (m_valid) begin
        last_dat = m_data;
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_beat: got 0x%0h, required no beat", m_data);
          end else begin
            check("beat_data", m_data, exp_q.pop_front());
            check("beat_last", 32'(m_last), 32'(bcnt == 15));
            check("beat_cnt", 32'(beat_cnt), 32'(bcnt));
            bcnt = (bcnt + 1) % 16;
          end
        end
      end else begin
        check("idle_hold", m_data, last_dat);
      end
      pv_stall = m_valid && !m_ready;
      pv_dat   = m_data;
      pv_cnt   = beat_cnt;
    end
  end

  always @(negedge rclk) begin
    if (rst2_n && valid2 && ready2) begin
      check("b2_data", 32'(data2), 32'(k2 + 1));
      check("b2_last", 32'(last2), 32'((k2 % 2) == 1));
      k2++;
    end
  end

  initial begin
    int   pops;
    logic got;
    rst_n  = 1'b0;
    m_ready = 1'b1;
    rst2_n = 1'b0;
    en2    = 1'b0;
    ready2 = 1'b1;

    for (int i = 1; i <= 32; i++) load(32'(i));
    repeat (3) begin
      @(negedge rclk);
      check("rst_ren", 32'(fifo_ren), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_cnt", 32'(beat_cnt), 32'd0);
      check("rst_data", m_data, 32'd0);
    end
    @(posedge rclk); #1;
    rst_n = 1'b1;

    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge rclk);
      if (m_valid) got = 1'b1;
    end
    check("first_beat_seen", 32'(got), 32'd1);
    if (got) begin
      for (int i = 1; i < 32; i++) begin
        @(negedge rclk);
        check("no_gap", 32'(m_valid), 32'd1);
      end
    end
    drain(200);

    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(32'h100 + 32'(i));
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (fifo_ren && !fifo_empty) pops++;
    end
    check("stall_pops", 32'(pops), 32'd2);
    check("stall_ren_low", 32'(fifo_ren), 32'd0);
    check("stall_head", m_data, 32'h100);
    check("stall_head_valid", 32'(m_valid), 32'd1);
    @(posedge rclk); #1;
    m_ready = 1'b1;
    drain(200);

    for (int i = 0; i < 20; i++) load(32'h200 + 32'(i));
    for (int i = 0; i < 80; i++) begin
      @(posedge rclk); #1;
      empty_force = ~empty_force;
      m_ready = 1'($urandom_range(0, 1));
    end
    empty_force = 1'b0;
    m_ready = 1'b1;
    drain(300);
    check("fifo_consumed", 32'(fq_n), 32'd0);

    for (int i = 0; i < 16; i++) load(32'h300 + 32'(i));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge rclk); #1;
      got = m_valid && (beat_cnt == 8'd5);
    end
    check("beat5_reached", 32'(got), 32'd1);
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    fq_n = 0;
    @(posedge rclk); #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_cnt", 32'(beat_cnt), 32'd0);
    check("mid_rst_data", m_data, 32'd0);
    check("mid_rst_ren", 32'(fifo_ren), 32'd0);
    rst_n = 1'b1;
    @(negedge rclk);
    check("post_rst_valid", 32'(m_valid), 32'd0);
    check("post_rst_cnt", 32'(beat_cnt), 32'd0);
    @(posedge rclk); #1;
    for (int i = 0; i < 4; i++) load(32'h400 + 32'(i));
    drain(200);

    rst2_n = 1'b1;
    en2    = 1'b1;
    for (int i = 0; i < 60 && k2 < 6; i++) @(posedge rclk);
    repeat (3) @(posedge rclk);
    #1;
    check("burst2_beats", 32'(k2), 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
